// File: rtl/pagerank_scatter_stream_if.sv
// rtl/pagerank_scatter_stream_if.sv - (dest_id, contribution) beat stream from scatter to gather.
interface pagerank_scatter_stream_if #(
  parameter int ID_W   = 32,
  parameter int RANK_W = 64
);
  logic              out_valid;
  logic              out_ready;
  logic [ID_W-1:0]   out_node_id;
  logic [RANK_W-1:0] out_rank;

  modport master (output out_valid, out_node_id, out_rank, input out_ready);
  modport slave  (input out_valid, out_node_id, out_rank, output out_ready);
endinterface

// File: rtl/pagerank_scatter_stream.sv
// rtl/pagerank_scatter_stream.sv - PageRank scatter: rank/out_degree per source, one beat per edge.
// Optional macro PAGERANK_SCATTER_SKIP_SELF_EN drops self-loop edges without emitting them.
module pagerank_scatter_stream #(
  parameter int NODES          = 4,
  parameter int MAX_OUT_DEGREE = 20,
  parameter int ID_W           = 32,
  parameter int DEG_W          = 32,
  parameter int RANK_W         = 64
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ID_W-1:0]     source_id     [NODES],
  input  logic [DEG_W-1:0]    out_degree    [NODES],
  input  logic [ID_W-1:0]     dest_id       [NODES][MAX_OUT_DEGREE],
  input  logic [RANK_W-1:0]   page_rank_old [NODES],
  pagerank_scatter_stream_if.master stream,
  output logic                busy,
  output logic                done,
  output logic [31:0]         edge_count
);
  localparam int IW = $clog2(NODES + 1);
  localparam int NW = (NODES > 1) ? $clog2(NODES) : 1;
  localparam int JW = $clog2(MAX_OUT_DEGREE + 1);
  localparam int SW = (MAX_OUT_DEGREE > 1) ? $clog2(MAX_OUT_DEGREE) : 1;
  localparam int CW = $clog2(RANK_W + 1);

  typedef enum logic [2:0] {IDLE, SCAN, DIVIDE, EMIT, DONE} state_t;
  state_t state;

  logic [ID_W-1:0]   src_q  [NODES];
  logic [DEG_W-1:0]  deg_q  [NODES];
  logic [ID_W-1:0]   dst_q  [NODES][MAX_OUT_DEGREE];
  logic [RANK_W-1:0] rank_q [NODES];

  logic [IW-1:0]     i;
  logic [JW-1:0]     j;
  logic [CW-1:0]     div_cnt;
  logic [DEG_W-1:0]  rem;
  logic [RANK_W-1:0] quo;

  logic [NW-1:0]     node;
  logic [DEG_W-1:0]  deg_node;
  logic [JW-1:0]     lim, jn;
  logic [SW-1:0]     slot_cur, slot_nxt;
  logic              end_cur, end_nxt, self_cur, self_nxt, skip_node;
  logic [DEG_W:0]    shifted;
  logic              ge;
  logic [DEG_W-1:0]  rem_n;
  logic [RANK_W-1:0] quo_n;

  always_comb begin
    node      = (i < IW'(NODES)) ? NW'(i) : '0;
    deg_node  = deg_q[node];
    // Degree above the slot count is clamped to the available adjacency slots.
    lim       = (deg_node > DEG_W'(MAX_OUT_DEGREE)) ? JW'(MAX_OUT_DEGREE) : JW'(deg_node);
    jn        = j + 1'b1;
    slot_cur  = (j  < JW'(MAX_OUT_DEGREE)) ? SW'(j)  : '0;
    slot_nxt  = (jn < JW'(MAX_OUT_DEGREE)) ? SW'(jn) : '0;
    end_cur   = (j  >= lim) || dst_q[node][slot_cur][ID_W-1];
    end_nxt   = (jn >= lim) || dst_q[node][slot_nxt][ID_W-1];
    skip_node = (deg_node == '0) || dst_q[node][0][ID_W-1];
    shifted   = {rem, quo[RANK_W-1]};
    ge        = shifted >= {1'b0, deg_node};
    rem_n     = DEG_W'(ge ? shifted - {1'b0, deg_node} : shifted);
    quo_n     = {quo[RANK_W-2:0], ge};
  end

`ifdef PAGERANK_SCATTER_SKIP_SELF_EN
  always_comb begin
    self_cur = dst_q[node][slot_cur] == src_q[node];
    self_nxt = dst_q[node][slot_nxt] == src_q[node];
  end
`else
  logic unused_src;
  always_comb begin
    self_cur   = 1'b0;
    self_nxt   = 1'b0;
    unused_src = 1'b0;
    for (int n = 0; n < NODES; n++) unused_src = unused_src ^ (^src_q[n]);
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      i                  <= '0;
      j                  <= '0;
      div_cnt            <= '0;
      rem                <= '0;
      quo                <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      edge_count         <= '0;
      stream.out_valid   <= 1'b0;
      stream.out_node_id <= '0;
      stream.out_rank    <= '0;
      for (int n = 0; n < NODES; n++) begin
        src_q[n]  <= '0;
        deg_q[n]  <= '0;
        rank_q[n] <= '0;
        for (int s = 0; s < MAX_OUT_DEGREE; s++) dst_q[n][s] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          src_q      <= source_id;
          deg_q      <= out_degree;
          dst_q      <= dest_id;
          rank_q     <= page_rank_old;
          i          <= '0;
          edge_count <= '0;
          busy       <= 1'b1;
          state      <= SCAN;
        end
        SCAN: begin
          if (i == IW'(NODES)) begin
            done  <= 1'b1;
            state <= DONE;
          end else if (skip_node) begin
            i <= i + 1'b1;
          end else begin
            j       <= '0;
            rem     <= '0;
            quo     <= rank_q[node];
            div_cnt <= '0;
            state   <= DIVIDE;
          end
        end
        DIVIDE: begin
          rem     <= rem_n;
          quo     <= quo_n;
          div_cnt <= div_cnt + 1'b1;
          if (div_cnt == CW'(RANK_W - 1)) begin
            stream.out_rank <= quo_n;
            state           <= EMIT;
          end
        end
        EMIT: begin
          // With no beat pending, slot j is either closed out, skipped, or loaded.
          if (!stream.out_valid) begin
            if (end_cur) begin
              i     <= i + 1'b1;
              state <= SCAN;
            end else if (self_cur) begin
              j <= jn;
            end else begin
              stream.out_valid   <= 1'b1;
              stream.out_node_id <= dst_q[node][slot_cur];
            end
          end else if (stream.out_ready) begin
            edge_count <= edge_count + 1'b1;
            j          <= jn;
            if (end_nxt) begin
              stream.out_valid <= 1'b0;
              i                <= i + 1'b1;
              state            <= SCAN;
            end else if (self_nxt) begin
              stream.out_valid <= 1'b0;
            end else begin
              stream.out_node_id <= dst_q[node][slot_nxt];
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/pagerank_scatter_stream.md
Name: pagerank_scatter_stream

Overview:
Parametrised PageRank scatter engine for one graph partition. On `start` it snapshots the partition's adjacency, out-degrees and old ranks. For each source vertex it computes `contribution = rank_old / out_degree` with a sequential restoring divider. It then streams one (dest_id, contribution) beat per outgoing edge over a valid/ready interface to the gather stage. It pulses `done` when the pass completes.

Parameters:
- NODES, 4, source vertices in partition.
- MAX_OUT_DEGREE, 20, adjacency slots per source vertex.
- ID_W, 32, vertex ID width.
- DEG_W, 32, out-degree width.
- RANK_W, 64, rank/contribution width (unsigned fixed point, divider iterations).

Ports:
- clock  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin pass; sampled only in IDLE.
- source_id  in  ID_W x NODES  vertex ID per partition slot.
- out_degree  in  DEG_W x NODES  out-degree per slot.
- dest_id  in  ID_W x NODES x MAX_OUT_DEGREE  destinations; MSB set = end-of-list sentinel.
- page_rank_old  in  RANK_W x NODES  previous-iteration rank per slot.
- out_valid  out  1  beat available.
- out_ready  in  1  gather stage accepts beat.
- out_node_id  out  ID_W  destination vertex of beat.
- out_rank  out  RANK_W  contribution of beat.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse at end of pass.
- edge_count  out  32  beats accepted in current/last pass.

Behaviour:
- Reset (async): state=IDLE; out_valid, out_node_id, out_rank, busy, done, edge_count all 0; snapshot registers and divider cleared. Reset mid-pass aborts immediately; no beats issued afterwards.
- States: IDLE, SCAN, DIVIDE, EMIT, DONE.
- IDLE:
  - start=1 at edge E0 → snapshot all array inputs, i=0, edge_count=0, busy=1, →SCAN.
  - Inputs are ignored after E0 until the next pass.
- SCAN (1 cycle):
  - i==NODES → DONE.
  - deg[i]==0 or dest_id[i][0] MSB set → i++, stay SCAN; no division, no beat.
  - Otherwise j=0, load divider, →DIVIDE.
- DIVIDE: restoring divider, exactly RANK_W cycles.
  - Quotient = floor(rank[i]/deg[i]), unsigned, truncating, zero-extended divisor.
  - Latched as contribution; →EMIT.
  - Divisor is never 0 (excluded in SCAN).
- EMIT:
  - out_valid=1, out_node_id=dest_id[i][j], out_rank=contribution, all registered.
  - Outputs held stable while out_valid && !out_ready.
  - On handshake (out_valid && out_ready): edge_count++, j++.
  - Node i ends when j reaches min(deg[i], MAX_OUT_DEGREE) or dest_id[i][j] has MSB set; then out_valid=0 next cycle, i++, →SCAN.
  - Degree > MAX_OUT_DEGREE is clamped.
  - Sustained throughput: 1 beat/cycle within a node.
- Latency: with start sampled at edge E0, the first out_valid rises after edge E0+RANK_W+2 (SCAN 1, DIVIDE RANK_W, EMIT entry 1).
- DONE (1 cycle): done=1, busy→0 next edge, →IDLE. edge_count holds until next start.
- start while busy is ignored; no queuing.
- Contribution is per source slot, indexed by partition slot i, never by destination ID.

Optional Feature:
- Macro: PAGERANK_SCATTER_SKIP_SELF_EN.
- Defined: edges with dest_id[i][j]==source_id[i] are consumed in one EMIT cycle with out_valid=0 and are not counted in edge_count. A node whose only edges are self-loops still spends its DIVIDE cycles.
- Undefined: self-loops are emitted as normal beats.

Test Plan (NODES=2, MAX_OUT_DEGREE=4, RANK_W=16):
1. Node0: rank 100, deg 3, dests 5,6,7. Node1: deg 0. out_ready=1. Pulse start → beats (5,33),(6,33),(7,33) on consecutive cycles, first valid after 18 edges; done pulses once; edge_count=3; node1 produces nothing.
2. Node0: rank 100, deg 4, dests 2, 0xFFFFFFFF. Node1: rank 9, deg 2, dests 4,8 → beats (2,25),(4,4),(8,4); edge_count=3.
3. As test 1, but out_ready held 0 for 5 cycles during beat 2 → out_valid stays 1, (6,33) stable, no beat lost or duplicated; edge_count=3.
4. Pulse start again mid-EMIT → ignored. Assert reset_n=0 during EMIT → out_valid, busy, edge_count become 0 immediately. After release, start runs a full clean pass.
5. Node0: source_id 9, rank 60, deg 2, dests 9,3. With macro → single beat (3,30), edge_count=1. Without macro → (9,30),(3,30), edge_count=2.
6. Node0: deg 6 (> MAX), dests 1,2,3,4 → exactly 4 beats, no read beyond slot 3.
